mux_4x1_scanner: RTL

Round-robin select sequencer that sits directly upstream of the 4-to-1 multiplexer, `mux_4x1_df`. It drives the mux's 2-bit select lines through channels 0 to 3. It holds each channel for a programmable dwell time and samples the mux output fed back into it. It then publishes the four captured bits as one frame word with a completion pulse. This turns the combinational mux into a scanned 4-channel input port.

---
 rtl/mux_4x1_scanner.sv | 76 +++++++
 1 files changed

// File: rtl/mux_4x1_scanner.sv
// mux_4x1_scanner: round-robin select sequencer that scans a 4:1 mux into a 4-bit frame word
module mux_4x1_scanner #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       start,
  input  logic       continuous,
  input  logic       abort,
  input  logic       mux_out,
  output logic [1:0] select,
  output logic [3:0] sample,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [7:0] LAST = 8'(DWELL - 1);
  state_t     state_q;
  logic [7:0] cnt_q;
  logic [1:0] sel_q;
  logic [2:0] shadow_q;
  logic [3:0] sample_q;
  logic       busy_q;
  logic       done_q;
  assign select = sel_q;
  assign sample = sample_q;
  assign busy   = busy_q;
  assign done   = done_q;
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SCAN;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          sel_q   <= '0;
        end
        SCAN: if (abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          sel_q   <= '0;
        end else if (cnt_q == LAST) begin
          cnt_q <= '0;
          if (sel_q == 2'd3) begin
            // last channel goes straight into the frame word, bypassing the shadow
            sample_q <= {mux_out, shadow_q};
            state_q  <= DONE;
            done_q   <= 1'b1;
            sel_q    <= '0;
          end else begin
            shadow_q[sel_q] <= mux_out;
            sel_q           <= sel_q + 2'd1;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= continuous ? SCAN : IDLE;
          busy_q  <= continuous;
          cnt_q   <= '0;
          sel_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
